// File: rtl/dac_display_scheduler.sv
// DAC monitor-mux sequencer: debounced buttons, manual/auto scan, frame-aligned switching with blanking.
// Define DAC_SCHED_MARKER_EN to build the frame-start trigger marker; otherwise marker is tied low.
module dac_display_scheduler #(
  parameter int unsigned NUM_WAVES       = 7,
  parameter int unsigned DWELL_FRAMES    = 16,
  parameter int unsigned BLANK_CYCLES    = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned MARKER_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_next,
  input  logic       btn_mode,
  input  logic       frame_sync,
  output logic [2:0] sel,
  output logic       auto_mode,
  output logic       blank,
  output logic       marker,
  output logic       switch_pending
);

  localparam int unsigned DW = $clog2(DWELL_FRAMES);
  localparam int unsigned BW = $clog2(BLANK_CYCLES + 1);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [2:0]    SEL_LAST   = 3'(NUM_WAVES - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_FRAMES - 1);
  localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYCLES);
  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);

  if (NUM_WAVES < 1 || NUM_WAVES > 8) begin : g_bad_num_waves
    $error("NUM_WAVES must be in 1..8 for a 3-bit select");
  end
  if (DWELL_FRAMES < 2) begin : g_bad_dwell
    $error("DWELL_FRAMES must be at least 2");
  end
  if (BLANK_CYCLES < 1) begin : g_bad_blank
    $error("BLANK_CYCLES must be at least 1");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (MARKER_CYCLES < 1) begin : g_bad_marker
    $error("MARKER_CYCLES must be at least 1");
  end

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } state_e;

  // Button debounce: bit 0 is btn_next, bit 1 is btn_mode.
  logic [1:0]    btn_raw;
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    stable_q, stable_d, stable_dly_q;
  logic [CW-1:0] db_cnt_q [2];
  logic [CW-1:0] db_cnt_d [2];
  logic [1:0]    press;
  logic          next_press, mode_press;

  assign btn_raw = {btn_mode, btn_next};

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      db_cnt_d[b] = '0;
      stable_d[b] = stable_q[b];
      if (sync2_q[b] != stable_q[b]) begin
        if (db_cnt_q[b] == DB_LAST) begin
          stable_d[b] = sync2_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      db_cnt_q[0]  <= '0;
      db_cnt_q[1]  <= '0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      db_cnt_q[0]  <= db_cnt_d[0];
      db_cnt_q[1]  <= db_cnt_d[1];
    end
  end

  assign press      = stable_q & ~stable_dly_q;
  assign next_press = press[0];
  assign mode_press = press[1];

  // Scheduler state
  state_e        state_q, state_d;
  logic [2:0]    sel_q, sel_d;
  logic          auto_q, auto_d;
  logic          pending_q, pending_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [BW-1:0] blank_cnt_q, blank_cnt_d;
  logic          blank_q, blank_d;
  logic          show_sync, fire;

  assign show_sync = (state_q == ST_SHOW) && frame_sync;
  assign fire      = show_sync && (pending_q || (auto_q && (dwell_q == DWELL_LAST)));

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    auto_d      = auto_q;
    pending_d   = pending_q;
    dwell_d     = dwell_q;
    blank_cnt_d = blank_cnt_q;

    case (state_q)
      ST_SHOW: begin
        if (fire) begin
          sel_d       = (sel_q == SEL_LAST) ? 3'd0 : sel_q + 3'd1;
          pending_d   = 1'b0;
          dwell_d     = '0;
          blank_cnt_d = BLANK_LOAD;
          state_d     = ST_BLANK;
        end else if (show_sync && auto_q) begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      ST_BLANK: begin
        blank_cnt_d = blank_cnt_q - BW'(1);
        if (blank_cnt_q <= BW'(1)) begin
          blank_cnt_d = '0;
          state_d     = ST_SHOW;
        end
      end
      default: begin
        state_d     = ST_SHOW;
        blank_cnt_d = '0;
      end
    endcase

    // Button events are applied after the switch decision so a coincident
    // press re-arms the next frame and a mode toggle uses the old mode here.
    if (next_press) begin
      pending_d = 1'b1;
    end
    if (mode_press) begin
      auto_d  = ~auto_q;
      dwell_d = '0;
    end

    blank_d = (state_d == ST_BLANK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SHOW;
      sel_q       <= '0;
      auto_q      <= 1'b0;
      pending_q   <= 1'b0;
      dwell_q     <= '0;
      blank_cnt_q <= '0;
      blank_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      auto_q      <= auto_d;
      pending_q   <= pending_d;
      dwell_q     <= dwell_d;
      blank_cnt_q <= blank_cnt_d;
      blank_q     <= blank_d;
    end
  end

`ifdef DAC_SCHED_MARKER_EN
  localparam int unsigned MW = $clog2(MARKER_CYCLES + 1);
  localparam logic [MW-1:0] MARKER_LOAD = MW'(MARKER_CYCLES);

  logic [MW-1:0] marker_cnt_q, marker_cnt_d;
  logic          marker_q, marker_d;

  // A non-switching frame start (re)starts the marker width.
  always_comb begin
    marker_cnt_d = marker_cnt_q;
    if (show_sync && !fire) begin
      marker_cnt_d = MARKER_LOAD;
    end else if (marker_cnt_q != '0) begin
      marker_cnt_d = marker_cnt_q - MW'(1);
    end
    marker_d = (marker_cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      marker_cnt_q <= '0;
      marker_q     <= 1'b0;
    end else begin
      marker_cnt_q <= marker_cnt_d;
      marker_q     <= marker_d;
    end
  end

  assign marker = marker_q;
`else
  assign marker = 1'b0;
`endif

  assign sel            = sel_q;
  assign auto_mode      = auto_q;
  assign blank          = blank_q;
  assign switch_pending = pending_q;

endmodule

// File: tb/tb_dac_display_scheduler.sv
// Self-checking bench for dac_display_scheduler: frame-level behavioural model plus directed literal checks.
module tb_dac_display_scheduler;

  localparam int NumWaves       = 7;
  localparam int DwellFrames    = 3;
  localparam int BlankCycles    = 8;
  localparam int DebounceCycles = 4;
  localparam int MarkerCycles   = 4;
  localparam int FramePeriod    = 100;
  localparam logic [63:0] WinMask = (64'd1 << DebounceCycles) - 64'd1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btnNext = 1'b0;
  logic       btnMode = 1'b0;
  logic       frameSync = 1'b0;
  logic [2:0] sel;
  logic       autoMode, blank, marker, switchPending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dac_display_scheduler #(
    .NUM_WAVES      (NumWaves),
    .DWELL_FRAMES   (DwellFrames),
    .BLANK_CYCLES   (BlankCycles),
    .DEBOUNCE_CYCLES(DebounceCycles),
    .MARKER_CYCLES  (MarkerCycles)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_next      (btnNext),
    .btn_mode      (btnMode),
    .frame_sync    (frameSync),
    .sel           (sel),
    .auto_mode     (autoMode),
    .blank         (blank),
    .marker        (marker),
    .switch_pending(switchPending)
  );

  // Model state: timestamps of window ends rather than down-counters,
  // and button stability judged over a window of synchronized samples.
  int          edgeCount = 0;
  int          expSel = 0;
  bit          expAuto = 1'b0;
  bit          expPending = 1'b0;
  int          expDwell = 0;
  int          blankEnd = 0;
  int          markerEnd = 0;
  logic [63:0] rawHist [2];
  logic [63:0] syncHist [2];
  bit          stable [2];
  int          lastFlip [2];
  int          riseEdge [2];

  function void modelReset();
    expSel     = 0;
    expAuto    = 1'b0;
    expPending = 1'b0;
    expDwell   = 0;
    blankEnd   = 0;
    markerEnd  = 0;
    for (int b = 0; b < 2; b++) begin
      rawHist[b]  = '0;
      syncHist[b] = '0;
      stable[b]   = 1'b0;
      lastFlip[b] = -1000000;
      riseEdge[b] = -1000000;
    end
  endfunction

  function void modelEdge();
    bit          nextEv, modeEv, inBlank, raw, s2, fire;
    logic [63:0] win;
    edgeCount = edgeCount + 1;
    nextEv  = (riseEdge[0] == edgeCount - 1);
    modeEv  = (riseEdge[1] == edgeCount - 1);
    inBlank = (edgeCount - 1) < blankEnd;
    for (int b = 0; b < 2; b++) begin
      raw = (b == 0) ? btnNext : btnMode;
      s2  = rawHist[b][1];
      rawHist[b]  = {rawHist[b][62:0], raw};
      syncHist[b] = {syncHist[b][62:0], s2};
      win = syncHist[b] & WinMask;
      if ((edgeCount - lastFlip[b] >= DebounceCycles) &&
          (win == (stable[b] ? 64'd0 : WinMask))) begin
        stable[b]   = !stable[b];
        lastFlip[b] = edgeCount;
        if (stable[b]) riseEdge[b] = edgeCount;
      end
    end
    if (frameSync && !inBlank) begin
      fire = expPending || (expAuto && expDwell == DwellFrames - 1);
      if (fire) begin
        expSel     = (expSel + 1) % NumWaves;
        expPending = 1'b0;
        expDwell   = 0;
        blankEnd   = edgeCount + BlankCycles;
      end else begin
        if (expAuto) expDwell = expDwell + 1;
        markerEnd = edgeCount + MarkerCycles;
      end
    end
    if (nextEv) expPending = 1'b1;
    if (modeEv) begin
      expAuto  = !expAuto;
      expDwell = 0;
    end
  endfunction

  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) modelReset();
      else modelEdge();
    end
  end

  task checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d, t=%0t)", name, actual, expected,
               edgeCount, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("cmp_sel", {29'd0, sel}, expSel);
      checkOutput("cmp_auto_mode", {31'd0, autoMode}, {31'd0, expAuto});
      checkOutput("cmp_switch_pending", {31'd0, switchPending}, {31'd0, expPending});
      checkOutput("cmp_blank", {31'd0, blank}, (edgeCount < blankEnd) ? 32'd1 : 32'd0);
`ifdef DAC_SCHED_MARKER_EN
      checkOutput("cmp_marker", {31'd0, marker}, (edgeCount < markerEnd) ? 32'd1 : 32'd0);
`else
      checkOutput("cmp_marker", {31'd0, marker}, 32'd0);
`endif
    end
  end

  task applyStimulus(input bit nxt, input bit mode, input bit fs);
    @(posedge clk);
    #1;
    btnNext   = nxt;
    btnMode   = mode;
    frameSync = fs;
  endtask

  task idle(input int n, input bit nxt, input bit mode);
    repeat (n) applyStimulus(nxt, mode, 1'b0);
  endtask

  task pressBtn(input bit which);
    idle(20, which == 1'b0, which == 1'b1);
    idle(20, 1'b0, 1'b0);
  endtask

  // Leaves the bench in the cycle right after the frame_sync cycle.
  task syncFrame();
    idle(FramePeriod - 1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  int autoSel [6];
  int autoMark [6];

  initial begin
    autoSel  = '{3, 3, 4, 4, 4, 5};
    autoMark = '{1, 1, 0, 1, 1, 0};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_sel", {29'd0, sel}, 0);
    checkOutput("rst_blank", {31'd0, blank}, 0);
    checkOutput("rst_pending", {31'd0, switchPending}, 0);
    checkOutput("rst_auto", {31'd0, autoMode}, 0);
    checkOutput("rst_marker", {31'd0, marker}, 0);
    rst_n = 1'b1;

    $display("[TB] manual advance latency");
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (6) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("pend_cycle6", {31'd0, switchPending}, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("pend_cycle7", {31'd0, switchPending}, 1);
    idle(12, 1'b1, 1'b0);
    idle(20, 1'b0, 1'b0);
    syncFrame();
    checkOutput("adv1_sel", {29'd0, sel}, 1);
    checkOutput("adv1_blank_first", {31'd0, blank}, 1);
    idle(7, 1'b0, 1'b0);
    checkOutput("adv1_blank_last", {31'd0, blank}, 1);
    idle(1, 1'b0, 1'b0);
    checkOutput("adv1_blank_end", {31'd0, blank}, 0);

    $display("[TB] reset during blanking");
    pressBtn(1'b0);
    syncFrame();
    pressBtn(1'b0);
    syncFrame();
    idle(2, 1'b0, 1'b0);
    checkOutput("prerst_sel", {29'd0, sel}, 3);
    checkOutput("prerst_blank", {31'd0, blank}, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_sel", {29'd0, sel}, 0);
    checkOutput("midrst_blank", {31'd0, blank}, 0);
    checkOutput("midrst_pending", {31'd0, switchPending}, 0);
    checkOutput("midrst_marker", {31'd0, marker}, 0);
    idle(2, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle(1, 1'b0, 1'b0);
    checkOutput("postrst_sel", {29'd0, sel}, 0);

    $display("[TB] wrap over all sources");
    for (int i = 0; i < 7; i++) begin
      pressBtn(1'b0);
      syncFrame();
      checkOutput("wrap_sel", {29'd0, sel}, (i + 1) % 7);
      idle(10, 1'b0, 1'b0);
    end

    $display("[TB] bounce filtering");
    for (int i = 0; i < 15; i++) idle(2, (i % 2) == 0, 1'b0);
    checkOutput("bounce_no_pending", {31'd0, switchPending}, 0);
    idle(20, 1'b1, 1'b0);
    idle(20, 1'b0, 1'b0);
    checkOutput("bounce_pending", {31'd0, switchPending}, 1);
    syncFrame();
    checkOutput("bounce_sel", {29'd0, sel}, 1);
    idle(10, 1'b0, 1'b0);
    checkOutput("bounce_cleared", {31'd0, switchPending}, 0);
    syncFrame();
    checkOutput("bounce_single_adv", {29'd0, sel}, 1);

    $display("[TB] press coincident with switching sync");
    pressBtn(1'b0);
    checkOutput("coll_pending_pre", {31'd0, switchPending}, 1);
    repeat (6) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("coll_sel", {29'd0, sel}, 2);
    checkOutput("coll_pending_again", {31'd0, switchPending}, 1);
    checkOutput("coll_blank", {31'd0, blank}, 1);

    $display("[TB] sync during blanking is ignored");
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("blanksync_sel", {29'd0, sel}, 2);
    checkOutput("blanksync_marker", {31'd0, marker}, 0);
    checkOutput("blanksync_pending", {31'd0, switchPending}, 1);
    idle(9, 1'b1, 1'b0);
    idle(20, 1'b0, 1'b0);
    syncFrame();
    checkOutput("blanksync_next_sel", {29'd0, sel}, 3);
    checkOutput("blanksync_next_pending", {31'd0, switchPending}, 0);

    $display("[TB] auto scan");
    pressBtn(1'b1);
    checkOutput("auto_on", {31'd0, autoMode}, 1);
    for (int f = 0; f < 6; f++) begin
      syncFrame();
      checkOutput("auto_sel", {29'd0, sel}, autoSel[f]);
`ifdef DAC_SCHED_MARKER_EN
      checkOutput("auto_marker_rise", {31'd0, marker}, autoMark[f]);
      idle(3, 1'b0, 1'b0);
      checkOutput("auto_marker_hold", {31'd0, marker}, autoMark[f]);
`else
      checkOutput("auto_marker_off", {31'd0, marker}, 0);
      idle(3, 1'b0, 1'b0);
`endif
      idle(1, 1'b0, 1'b0);
      checkOutput("auto_marker_end", {31'd0, marker}, 0);
    end

    idle(5, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
